// File: rtl/ram_if_pkg.sv
// Shared types and defaults for the burst initiator in front of the
// 64x8 synchronous single-port RAM.
package ram_if_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 8;
    localparam int DEPTH  = 2 ** AW_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// Burst address/count generator: loads start and length, advances one
// beat per step and wraps naturally at the address width.
module ram_burst_addr_gen
    import ram_if_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] start,
    input  logic [AW-1:0] len,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          left,
    output logic          last
);

    logic [AW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
            left  <= 1'b0;
        end else if (load) begin
            addr  <= start;
            count <= len;
            left  <= 1'b1;
        end else if (step && left) begin
            addr <= addr + 1'b1;
            if (count == '0) begin
                left <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign last = left && (count == '0);

endmodule

// File: rtl/ram_burst_initiator.sv
// Burst read/write initiator: command handshake, beat streaming with
// backpressure, and RAM pin driving with reset-gated outputs.
module ram_burst_initiator
    import ram_if_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_cs,
    output logic          mem_rw,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state;
    state_t        next;
    logic          load;
    logic          step;
    logic          issue;
    logic          cs_c;
    logic          cmd_rdy_c;
    logic          wr_rdy_c;
    logic          done_c;
    logic          rd_vld;
    logic [AW-1:0] gen_addr;
    logic          gen_left;
    logic          gen_last;

    ram_burst_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .start (cmd_addr),
        .len   (cmd_len),
        .step  (step),
        .addr  (gen_addr),
        .left  (gen_left),
        .last  (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        load      = 1'b0;
        step      = 1'b0;
        issue     = 1'b0;
        cs_c      = 1'b0;
        cmd_rdy_c = 1'b0;
        wr_rdy_c  = 1'b0;
        done_c    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_rdy_c = 1'b1;
                if (cmd_valid) begin
                    load = 1'b1;
                    next = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_rdy_c = 1'b1;
                if (wr_valid) begin
                    cs_c = 1'b1;
                    step = 1'b1;
                    if (gen_last) begin
                        next = DONE;
                    end
                end
            end
            READ: begin
                // Single-entry output slot: issue only if it is empty or draining.
                issue = gen_left && (!rd_vld || rd_ready);
                cs_c  = issue;
                step  = issue;
                if (rd_vld && rd_ready && !gen_left) begin
                    next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                next   = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
        end else if (issue) begin
            rd_vld <= 1'b1;
        end else if (rd_ready) begin
            rd_vld <= 1'b0;
        end
    end

    // Reset gates outputs combinationally so a mid-burst reset never strobes the RAM.
    assign cmd_ready = cmd_rdy_c && rst_n;
    assign wr_ready  = wr_rdy_c && rst_n;
    assign rd_valid  = rd_vld && rst_n;
    assign rd_data   = mem_dout;
    assign busy      = (state != IDLE) && rst_n;
    assign done      = done_c && rst_n;
    assign mem_cs    = cs_c && rst_n;
    assign mem_rw    = (state == WRITE) && rst_n;
    assign mem_addr  = rst_n ? gen_addr : '0;
    assign mem_din   = (rst_n && state == WRITE) ? wr_data : '0;

endmodule

// File: tb/tb_ram_burst_initiator.sv
// Scoreboard bench for ram_burst_initiator with a behavioural 64x8 RAM.
module tb_ram_burst_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [5:0] mem_addr;
    logic       mem_cs;
    logic       mem_rw;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] ram [64];
    logic [7:0] ram_q;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [5:0] wq_a[$];
    logic [7:0] wq_d[$];
    logic [7:0] rq[$];

    always #5 clk = ~clk;

    ram_burst_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_cs    (mem_cs),
        .mem_rw    (mem_rw),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_rw) ram[mem_addr] <= mem_din;
            else ram_q <= ram[mem_addr];
        end
    end
    assign mem_dout = ram_q;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a beat.
    always @(negedge clk) begin
        if (mem_cs && mem_rw) begin
            if (wq_a.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                chk("wr_addr", mem_addr, wq_a.pop_front());
                chk("wr_data", mem_din, wq_d.pop_front());
            end
        end
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rd_data", rd_data, rq.pop_front());
        end
        if (done) done_cnt++;
    end

    task automatic send_cmd(input bit w, input logic [5:0] a,
                            input logic [5:0] l);
        bit ok = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 0;
        exp_done++;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt >= exp_done) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        chk({nm, "_done_seen"}, ok, 1);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_done_once"}, done_cnt, exp_done);
        chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic write_burst(input logic [5:0] a, input logic [5:0] l,
                               input logic [7:0] d [64], input bit gaps);
        send_cmd(1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (gaps && i > 0) begin
                wr_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            wr_valid = 1'b1;
            wr_data  = d[i];
            wq_a.push_back(a + 6'(i));
            wq_d.push_back(d[i]);
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wait_done("write");
    endtask

    task automatic read_burst(input logic [5:0] a, input logic [5:0] l,
                              input logic [7:0] e [64], input bit stall);
        int vcnt = 0;
        bit ok = 0;
        for (int i = 0; i <= int'(l); i++) rq.push_back(e[i]);
        send_cmd(0, a, l);
        rd_ready = !stall;
        if (stall) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rd_valid) begin
                    ok = 1;
                    break;
                end
            end
            chk("first_rd_valid", ok, 1);
            for (int i = 0; i < 3; i++) begin
                chk("stall_data", rd_data, e[0]);
                chk("stall_valid", rd_valid, 1);
                chk("stall_cs", mem_cs, 0);
                @(posedge clk);
                #1;
                if (i == 2) rd_ready = 1'b1;
                else @(negedge clk);
            end
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
            if (rd_valid) vcnt++;
        end
        if (!stall) chk("rd_beats_consecutive", vcnt, int'(l) + 1);
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        exp_done--;
        exp_done++;
        wait_done("read");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d [64];
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        ram_q     = 8'h00;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        write_burst(6'd0, 6'd3, d, 0);
        read_burst(6'd0, 6'd3, d, 0);
        read_burst(6'd0, 6'd3, d, 1);

        d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
        write_burst(6'd62, 6'd3, d, 0);
        chk("ram62", ram[62], 8'hA0);
        chk("ram63", ram[63], 8'hA1);
        chk("ram0", ram[0], 8'hA2);
        chk("ram1", ram[1], 8'hA3);
        d[0] = 8'hA1; d[1] = 8'hA2;
        read_burst(6'd63, 6'd1, d, 0);

        d[0] = 8'h51; d[1] = 8'h52; d[2] = 8'h53; d[3] = 8'h54;
        write_burst(6'd8, 6'd3, d, 1);
        read_burst(6'd8, 6'd3, d, 0);

        for (int i = 0; i < 64; i++) d[i] = 8'(i) ^ 8'h5A;
        write_burst(6'd0, 6'd63, d, 0);
        read_burst(6'd0, 6'd63, d, 0);

        // Abandon a write burst after two beats.
        send_cmd(1, 6'd0, 6'd3);
        wr_valid = 1'b1;
        wr_data  = 8'hC0;
        wq_a.push_back(6'd0);
        wq_d.push_back(8'hC0);
        @(posedge clk);
        #1;
        wr_data = 8'hC1;
        wq_a.push_back(6'd1);
        wq_d.push_back(8'hC1);
        @(posedge clk);
        #1;
        wr_data = 8'hC2;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs", mem_cs, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rw", mem_rw, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_din", mem_din, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        chk("ram2_kept", ram[2], 8'h58);
        chk("ram3_kept", ram[3], 8'h59);
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        d[0] = 8'h77;
        write_burst(6'd2, 6'd0, d, 0);
        d[0] = 8'hC0; d[1] = 8'hC1; d[2] = 8'h77; d[3] = 8'h59;
        read_burst(6'd0, 6'd3, d, 0);

        repeat (3) @(posedge clk);
        chk("wq_empty", wq_a.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
